// File: rtl/core_bus_scheduler.sv
// rtl/core_bus_scheduler.sv - serialises commands onto the shared core bus; optional counters via SCHED_PERF_CNT_EN
module core_bus_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int CORE_SPAN = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [7:0]             cmd_instruction_i,
    input  logic [23:0]            cmd_address_i,
    input  logic [31:0]            cmd_value_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_result_o,
    output logic [1:0]             rsp_status_o,
    output logic [NUM_CORES-1:0]   core_sel_o,
    output logic [7:0]             core_instruction_o,
    output logic [23:0]            core_address_o,
    output logic [31:0]            core_value_o,
`ifdef SCHED_PERF_CNT_EN
    output logic [15:0]            txn_count_o,
    output logic [7:0]             timeout_count_o,
`endif
    input  logic [NUM_CORES-1:0]   core_done_i,
    input  logic [32*NUM_CORES-1:0] core_result_i
);

    localparam int          SPAN_LOG2 = $clog2(CORE_SPAN);
    localparam logic [23:0] SPAN_MASK = 24'(CORE_SPAN - 1);
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DECERR  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_result_q;
    logic [1:0]             rsp_status_q;
    logic [NUM_CORES-1:0]   core_sel_q;
    logic [NUM_CORES-1:0]   sel_mask_q;
    logic [7:0]             core_instruction_q;
    logic [23:0]            core_address_q;
    logic [31:0]            core_value_q;
    logic [7:0]             cmd_instruction_q;
    logic [23:0]            cmd_address_q;
    logic [31:0]            cmd_value_q;
    logic [7:0]             wait_cnt_q;

    logic [23:0]            decode_idx_d;
    logic                   decode_err_d;
    logic [NUM_CORES-1:0]   sel_d;
    logic                   done_hit_d;
    logic [31:0]            result_sel_d;
    logic                   timeout_hit_d;

    // Address decode to a one-hot core mask, plus done/result steering from the owning core
    always_comb begin
        decode_idx_d  = cmd_address_q >> SPAN_LOG2;
        decode_err_d  = (decode_idx_d >= 24'(NUM_CORES));
        sel_d         = '0;
        result_sel_d  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            sel_d[k]     = (decode_idx_d == 24'(k));
            result_sel_d = result_sel_d | (core_result_i[k*32 +: 32] & {32{sel_mask_q[k]}});
        end
        done_hit_d    = |(core_done_i & sel_mask_q);
        timeout_hit_d = !done_hit_d && (wait_cnt_q == WAIT_LAST);
    end

    // Transaction FSM with all bus and response outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q            <= S_IDLE;
            cmd_ready_q        <= 1'b1;
            rsp_valid_q        <= 1'b0;
            rsp_result_q       <= '0;
            rsp_status_q       <= ST_OK;
            core_sel_q         <= '0;
            sel_mask_q         <= '0;
            core_instruction_q <= '0;
            core_address_q     <= '0;
            core_value_q       <= '0;
            cmd_instruction_q  <= '0;
            cmd_address_q      <= '0;
            cmd_value_q        <= '0;
            wait_cnt_q         <= '0;
        end else begin
            core_sel_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        cmd_instruction_q <= cmd_instruction_i;
                        cmd_address_q     <= cmd_address_i;
                        cmd_value_q       <= cmd_value_i;
                        cmd_ready_q       <= 1'b0;
                        state_q           <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (decode_err_d) begin
                        rsp_result_q <= '0;
                        rsp_status_q <= ST_DECERR;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (cmd_instruction_q == 8'h00) begin
                        rsp_result_q <= '0;
                        rsp_status_q <= ST_OK;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        core_sel_q         <= sel_d;
                        sel_mask_q         <= sel_d;
                        core_instruction_q <= cmd_instruction_q;
                        core_address_q     <= cmd_address_q & SPAN_MASK;
                        core_value_q       <= cmd_value_q;
                        state_q            <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 8'd1;
                    if (done_hit_d) begin
                        rsp_result_q <= result_sel_d;
                        rsp_status_q <= ST_OK;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (timeout_hit_d) begin
                        rsp_result_q <= '0;
                        rsp_status_q <= ST_TIMEOUT;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [15:0] txn_count_q;
    logic [7:0]  timeout_count_q;

    // Saturating counters of completed handshakes and timeout responses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txn_count_q     <= '0;
            timeout_count_q <= '0;
        end else begin
            if (state_q == S_RESP && rsp_ready_i && txn_count_q != 16'hFFFF) begin
                txn_count_q <= txn_count_q + 16'd1;
            end
            if (state_q == S_WAIT && timeout_hit_d && timeout_count_q != 8'hFF) begin
                timeout_count_q <= timeout_count_q + 8'd1;
            end
        end
    end

    assign txn_count_o     = txn_count_q;
    assign timeout_count_o = timeout_count_q;
`endif

    assign cmd_ready_o        = cmd_ready_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_result_o       = rsp_result_q;
    assign rsp_status_o       = rsp_status_q;
    assign core_sel_o         = core_sel_q;
    assign core_instruction_o = core_instruction_q;
    assign core_address_o     = core_address_q;
    assign core_value_o       = core_value_q;

endmodule
